// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div sequencer: FSM encoding, op codes and the default iteration count.
package muldiv_pkg;

    localparam int   CYCLES_DEFAULT = 32;
    localparam logic OP_MULT        = 1'b0;
    localparam logic OP_DIV         = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_EXC   = 3'd4
    } state_t;

    // One extra bit lets the counter step past CYCLES-1 without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Iteration counter for the mult/div sequencer with synchronous clear and terminal-count flag.
module muldiv_cycle_counter
    import muldiv_pkg::*;
#(
    parameter int CYCLES = CYCLES_DEFAULT,
    parameter int W      = cnt_width(CYCLES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == W'(CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Control FSM that clears, runs and unloads the iterative mult/div unit, flagging divide-by-zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int CYCLES = CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op,
    input  logic div_zero,
    output logic md_sel,
    output logic md_clear,
    output logic load_hi,
    output logic load_lo,
    output logic busy,
    output logic done,
    output logic exc_div0
);

    localparam int CW = cnt_width(CYCLES);

    state_t        state_q, state_d;
    logic          md_sel_q, md_sel_d;
    logic          cnt_clear, cnt_en;
    logic [CW-1:0] count;
    logic          cnt_tc;

    muldiv_cycle_counter #(
        .CYCLES (CYCLES),
        .W      (CW)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (count),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        md_sel_d  = md_sel_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    md_sel_d = op;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_clear = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                // The unit only reports a zero divisor reliably in the first iteration.
                if ((count == '0) && (md_sel_q == OP_DIV) && div_zero) begin
                    state_d = ST_EXC;
                end else if (cnt_tc) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_EXC:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            md_sel_q <= OP_MULT;
        end else begin
            state_q  <= state_d;
            md_sel_q <= md_sel_d;
        end
    end

    assign md_sel   = md_sel_q;
    assign md_clear = (state_q == ST_CLEAR);
    assign load_hi  = (state_q == ST_WRITE);
    assign load_lo  = (state_q == ST_WRITE);
    assign done     = (state_q == ST_WRITE);
    assign exc_div0 = (state_q == ST_EXC);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: default CYCLES=32 instance plus a CYCLES=4 instance.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start, op, div_zero;
    logic md_sel, md_clear, load_hi, load_lo, busy, done, exc_div0;
    logic start4, op4, dz4;
    logic md_sel4, md_clear4, load_hi4, load_lo4, busy4, done4, exc4;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    muldiv_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .div_zero(div_zero),
        .md_sel(md_sel), .md_clear(md_clear), .load_hi(load_hi), .load_lo(load_lo),
        .busy(busy), .done(done), .exc_div0(exc_div0)
    );

    muldiv_sequencer #(.CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op4), .div_zero(dz4),
        .md_sel(md_sel4), .md_clear(md_clear4), .load_hi(load_hi4), .load_lo(load_lo4),
        .busy(busy4), .done(done4), .exc_div0(exc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the current cycle (start driven now); checks are made mid-cycle.
    // dz_c/s1/s2: cycles in which div_zero/start are driven; d_c/x_c: expected done/exc cycle (-1 = never).
    task automatic run_op(input logic opv, input int dz_c, input int s1, input int s2,
                          input int d_c, input int x_c, input string tag);
        int last;
        last = (d_c > 0) ? d_c : x_c;
        start = 1'b1; op = opv; div_zero = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d done", tag, c),     32'(done),     32'(c == d_c));
            chk($sformatf("%s c%0d load_hi", tag, c),  32'(load_hi),  32'(c == d_c));
            chk($sformatf("%s c%0d load_lo", tag, c),  32'(load_lo),  32'(c == d_c));
            chk($sformatf("%s c%0d exc_div0", tag, c), 32'(exc_div0), 32'(c == x_c));
            chk($sformatf("%s c%0d busy", tag, c),     32'(busy),     32'(c <= last));
            chk($sformatf("%s c%0d md_clear", tag, c), 32'(md_clear), 32'(c == 1));
            chk($sformatf("%s c%0d md_sel", tag, c),   32'(md_sel),   32'(opv));
            start    = (c == s1) || (c == s2);
            div_zero = (c == dz_c);
            op       = ~opv;
        end
        start = 1'b0; div_zero = 1'b0; op = OP_MULT;
    endtask

    initial begin
        int n3;
        reset = 1'b1; start = 1'b0; op = 1'b0; div_zero = 1'b0;
        start4 = 1'b0; op4 = 1'b0; dz4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst md_sel", 32'(md_sel), 32'd0);
        chk("rst outs", {26'd0, md_clear, load_hi, load_lo, done, exc_div0, busy4}, 32'd0);
        chk("rst count", 32'(u_dut.count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(OP_MULT, -1, -1, -1, 34, -1, "mult");
        run_op(OP_DIV,  -1, -1, -1, 34, -1, "div_b2b");
        run_op(OP_DIV,   2, -1, -1, -1,  3, "div_zero");
        run_op(OP_DIV,   5, -1, -1, 34, -1, "div_dz_late");
        run_op(OP_MULT,  2, -1, -1, 34, -1, "mult_dz");
        run_op(OP_MULT, -1, 10, 34, 34, -1, "start_ign");
        run_op(OP_DIV,  -1, -1, -1, 34, -1, "after_ign");

        // Abort a MULT in cycle 20 with an asynchronous reset.
        start = 1'b1; op = OP_MULT;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort outs", {27'd0, md_clear, load_hi, load_lo, done, exc_div0}, 32'd0);
        chk("abort md_sel", 32'(md_sel), 32'd0);
        chk("abort count", 32'(u_dut.count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst c%0d done", c), 32'(done), 32'd0);
            chk($sformatf("post_rst c%0d busy", c), 32'(busy), 32'd0);
        end
        run_op(OP_MULT, -1, -1, -1, 34, -1, "fresh");

        // Short build: done in cycle 6, counter passes 3 exactly once.
        n3 = 0;
        start4 = 1'b1; op4 = OP_MULT;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            chk($sformatf("c4 c%0d done", c), 32'(done4), 32'(c == 6));
            chk($sformatf("c4 c%0d busy", c), 32'(busy4), 32'(c <= 6));
            chk($sformatf("c4 c%0d exc", c),  32'(exc4),  32'd0);
            if (u_dut4.count == 3'd3) n3++;
        end
        chk("c4 count3 once", 32'(n3), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter CYCLES, default 32, SHALL set the number of iteration cycles the mult/div unit needs before Hi/Lo are valid.
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request from the control unit to begin an operation.
REQ-005 op  input  1  operation select: 0 = MULT, 1 = DIV; sampled only when a start is accepted.
REQ-006 div_zero  input  1  divide-by-zero flag from the mult/div unit.
REQ-007 md_sel  output  1  drives the mult/div unit's operation-select input; holds the latched op.
REQ-008 md_clear  output  1  synchronous clear pulse to the mult/div unit.
REQ-009 load_hi  output  1  load enable for register Hi.
REQ-010 load_lo  output  1  load enable for register Lo.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 exc_div0  output  1  one-cycle pulse on the divide-by-zero exception.

Function
REQ-014 The block SHALL implement the FSM states IDLE, CLEAR, RUN, WRITE and EXC.
REQ-015 In IDLE, start=1 SHALL latch op into md_sel and move the FSM to CLEAR on the next edge.
REQ-016 CLEAR SHALL last 1 cycle with md_clear=1, load the counter to 0, then move to RUN.
REQ-017 RUN SHALL increment a counter each cycle and move to WRITE in the cycle where counter = CYCLES-1, giving exactly CYCLES RUN cycles.
REQ-018 In the first RUN cycle (counter = 0), if md_sel=1 and div_zero=1, the FSM SHALL go to EXC instead of continuing.
REQ-019 div_zero SHALL be ignored in all other cycles and whenever md_sel=0.
REQ-020 WRITE SHALL last 1 cycle with load_hi=1, load_lo=1 and done=1, then return to IDLE.
REQ-021 EXC SHALL last 1 cycle with exc_div0=1 and load_hi=load_lo=0 (Hi/Lo keep their old values), then return to IDLE.
REQ-022 busy SHALL be 1 in CLEAR, RUN, WRITE and EXC, and 0 in IDLE.
REQ-023 start SHALL be ignored while busy=1, including in the WRITE/EXC cycle; there is no queueing.
REQ-024 Latency: for a start sampled at edge N, done SHALL be high in cycle N+CYCLES+2, and busy SHALL fall at edge N+CYCLES+3.
REQ-025 Back-to-back operation: a start sampled in the first IDLE cycle after WRITE SHALL be accepted normally.
REQ-026 md_sel SHALL stay stable from CLEAR through WRITE/EXC.
REQ-027 The counter width SHALL be clog2(CYCLES)+1 bits; the counter SHALL never wrap within an operation.
REQ-028 All outputs SHALL be registered-state decodes, with no combinational path from start or div_zero to any output.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, counter=0, md_sel=0, and md_clear, load_hi, load_lo, busy, done and exc_div0 all to 0.
REQ-030 A reset in the middle of an operation SHALL abort it with no Hi/Lo load and no done or exc_div0 pulse.
REQ-031 The first start after reset is released SHALL be handled as a fresh operation.

Structure
REQ-032 Package muldiv_pkg SHALL hold the FSM state encoding, the op constants OP_MULT=0 and OP_DIV=1, and the default CYCLES=32.
REQ-033 The iteration counter SHALL be a sub-module muldiv_cycle_counter (clear, enable, terminal-count output); all other logic stays in muldiv_sequencer.

Verification
REQ-034 MULT: start=1, op=0 at cycle 0 -> md_clear=1 in cycle 1; load_hi=load_lo=done=1 only in cycle 34; busy=1 for cycles 1-34.
REQ-035 DIV with div_zero=1: start=1, op=1 -> exc_div0=1 in cycle 3; done, load_hi and load_lo never asserted; busy=0 from cycle 4.
REQ-036 DIV with div_zero=1 only in RUN cycle 5 -> ignored; done=1 in cycle 34.
REQ-037 start pulsed in cycles 10 and 34 of a running op -> both ignored; exactly one done; a start in cycle 35 is accepted with done in cycle 69.
REQ-038 reset asserted in cycle 20 of a MULT -> all outputs 0 within that cycle; no done; a new start after release completes in CYCLES+2 cycles.
REQ-039 CYCLES=4 build: start at cycle 0 -> done in cycle 6; the counter reaches 3 exactly once.
